ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single RAM controller between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Sits between the core's memory ports and the RAM controller's core-side interface (address, mask, triggers, ready, error).
- Sequences one transaction at a time and returns read data and completion to the winning port.
- Fully in the core clock domain. The RAM controller handles all MIG/ui_clk crossing.

Parameters:
- ADDRESS_SIZE, 28, byte/word address width passed to the RAM controller
- DATA_SIZE, 32, data width of read/write values
- MASK_SIZE, DATA_SIZE/8, byte-enable width

Ports:
- clk  in  1  core clock, single clock domain
- reset  in  1  synchronous, active-high reset
- p0_req, p1_req  in  1  request; held high with stable fields until pN_done
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_address, p1_address  in  ADDRESS_SIZE  target address
- p0_mask, p1_mask  in  MASK_SIZE  byte enables
- p0_write_value, p1_write_value  in  DATA_SIZE  write data
- p0_done, p1_done  out  1  one-cycle completion pulse
- p0_read_value, p1_read_value  out  DATA_SIZE  read data, valid while pN_done=1 and held afterwards
- ram_address  out  ADDRESS_SIZE  to RAM controller address
- ram_mask  out  MASK_SIZE  to RAM controller mask
- ram_write_trigger, ram_read_trigger  out  1  one-cycle command pulses
- ram_write_value  out  DATA_SIZE  write data
- ram_read_value  in  DATA_SIZE  read data from RAM controller
- ram_read_value_ready  in  1  read data valid
- ram_controller_ready  in  1  RAM controller idle
- ram_error  in  4  RAM controller error code
- fault  out  1  sticky error indication
- grant_owner  out  1  port index of the current/last grant

Behaviour:
- All outputs are registered.
- Reset values: every done/trigger/fault = 0; all read values, ram_address, ram_mask, ram_write_value = 0; grant_owner = 0; state = IDLE.
- Reset in any state aborts the transaction with no done pulse. The RAM controller is not reset by this block.
- States: IDLE, WAIT_ACCEPT, WAIT_DONE, RELEASE, FAULT.
- IDLE:
  - If ram_error != 0, go to FAULT.
  - Else if ram_controller_ready=1 and any req: the picker selects a port, its fields are latched into ram_*, and exactly one trigger pulses in the next cycle. Then go to WAIT_ACCEPT.
  - Latency from req sampled to trigger high is 1 cycle.
- WAIT_ACCEPT:
  - Ignore ram_controller_ready for the trigger cycle itself.
  - Advance to WAIT_DONE on the first cycle ram_controller_ready=0.
  - If ram_error != 0, go to FAULT.
- WAIT_DONE:
  - Read: on ram_read_value_ready=1, capture ram_read_value into pN_read_value, pulse pN_done the next cycle, go to RELEASE.
  - Write: on ram_controller_ready=1, pulse pN_done the next cycle, go to RELEASE.
  - If ram_error != 0, go to FAULT.
- RELEASE: exactly one cycle in which req inputs are not sampled, so the requester can drop req after done. Then go to IDLE.
- FAULT:
  - fault=1, no further triggers, no done pulses.
  - Exit only via reset.
- Ownership: the non-granted port's req is held pending and never lost. Its outputs stay 0/held.
- Simultaneous req: resolved by the picker (default: port 0 wins).
- Back-to-back requests from the same port: minimum 1 idle cycle (RELEASE) between transactions.
- Never more than one outstanding command.

Optional Feature:
- Macro: RAM_PORT_ARBITER_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port not granted last wins, and grant_owner toggles priority after each completed grant.
- Undefined: fixed priority, port 0 always wins ties. Port 1 can starve under continuous port 0 traffic.

Decomposition:
- Package ram_arbiter_pkg:
  - State enum RAM_ARBITER_STATE (IDLE, WAIT_ACCEPT, WAIT_DONE, RELEASE, FAULT)
  - Port index constants PORT_FETCH=0, PORT_DATA=1
  - RAM_ERROR_NONE=4'd0
- One sub-module: ram_arbiter_pick, the combinational winner select.
  - Inputs: req vector, last grant.
  - Outputs: grant valid, index.
  - Holds the round-robin/fixed logic under the macro.

Test Plan:
- Write: p1 write, addr 0x0000100, data 0xDEADBEEF, mask 4'hF -> ram_write_trigger pulses once 1 cycle later with those values; p1_done pulses once after ram_controller_ready returns high; p0_done stays 0.
- Read: p0 read, addr 0x0000100; bench model returns 0xDEADBEEF with ram_read_value_ready -> p0_read_value=0xDEADBEEF while p0_done=1; exactly one ram_read_trigger.
- Simultaneous: p0 and p1 both req in the same cycle -> without macro, p0 served first, then p1 after RELEASE. With macro and last grant=0, p1 served first.
- Starvation: p0 reqs continuously while p1 holds req -> without macro, p1 never granted over 20 transactions; with macro, grants alternate 0,1,0,1.
- Reset: reset asserted in WAIT_DONE of a read -> next cycle all outputs at reset values, no done pulse; a fresh request after reset completes normally.
- Error: ram_error=4'd1 asserted in WAIT_DONE -> fault=1 the next cycle, no done pulses, further reqs produce no triggers until reset.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encoding and constants for the RAM port arbiter
package ram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_ACCEPT = 3'd1,
    WAIT_DONE   = 3'd2,
    RELEASE     = 3'd3,
    FAULT       = 3'd4
  } ram_arbiter_state_t;

  localparam logic       PORT_FETCH     = 1'b0;
  localparam logic       PORT_DATA      = 1'b1;
  localparam logic [3:0] RAM_ERROR_NONE = 4'd0;

endpackage

// File: rtl/ram_arbiter_pick.sv
// rtl/ram_arbiter_pick.sv - combinational winner select between the two requesters
// RAM_PORT_ARBITER_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise port 0 wins.
module ram_arbiter_pick
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       idx_o
);

  assign valid_o = |req_i;

`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
  assign idx_o = (&req_i) ? ~last_i : req_i[PORT_DATA];
`else
  logic unused_last;
  assign unused_last = last_i;
  assign idx_o = req_i[PORT_DATA] & ~req_i[PORT_FETCH];
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one RAM controller between fetch (port 0) and load/store (port 1)
// Tie-break policy lives in ram_arbiter_pick (RAM_PORT_ARBITER_ROUND_ROBIN_EN).
module ram_port_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE = 28,
  parameter int DATA_SIZE    = 32,
  parameter int MASK_SIZE    = DATA_SIZE / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDRESS_SIZE-1:0] p0_address,
  input  logic [MASK_SIZE-1:0]    p0_mask,
  input  logic [DATA_SIZE-1:0]    p0_write_value,
  output logic                    p0_done,
  output logic [DATA_SIZE-1:0]    p0_read_value,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDRESS_SIZE-1:0] p1_address,
  input  logic [MASK_SIZE-1:0]    p1_mask,
  input  logic [DATA_SIZE-1:0]    p1_write_value,
  output logic                    p1_done,
  output logic [DATA_SIZE-1:0]    p1_read_value,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [MASK_SIZE-1:0]    ram_mask,
  output logic                    ram_write_trigger,
  output logic                    ram_read_trigger,
  output logic [DATA_SIZE-1:0]    ram_write_value,
  input  logic [DATA_SIZE-1:0]    ram_read_value,
  input  logic                    ram_read_value_ready,
  input  logic                    ram_controller_ready,
  input  logic [3:0]              ram_error,
  output logic                    fault,
  output logic                    grant_owner
);

  ram_arbiter_state_t state_q, state_d;
  logic                    we_q, we_d;
  logic                    owner_q, owner_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [MASK_SIZE-1:0]    mask_q, mask_d;
  logic [DATA_SIZE-1:0]    wval_q, wval_d;
  logic [DATA_SIZE-1:0]    rval0_q, rval0_d, rval1_q, rval1_d;
  logic                    done0_q, done0_d, done1_q, done1_d;
  logic                    wtrig_q, wtrig_d, rtrig_q, rtrig_d;
  logic                    fault_q, fault_d;

  logic                    pick_valid, pick_idx;
  logic                    sel_we;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [MASK_SIZE-1:0]    sel_mask;
  logic [DATA_SIZE-1:0]    sel_wval;
  logic                    ram_err;

  ram_arbiter_pick u_pick (
    .req_i   ({p1_req, p0_req}),
    .last_i  (owner_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign sel_we   = (pick_idx == PORT_DATA) ? p1_we          : p0_we;
  assign sel_addr = (pick_idx == PORT_DATA) ? p1_address     : p0_address;
  assign sel_mask = (pick_idx == PORT_DATA) ? p1_mask        : p0_mask;
  assign sel_wval = (pick_idx == PORT_DATA) ? p1_write_value : p0_write_value;
  assign ram_err  = (ram_error != RAM_ERROR_NONE);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wval_d  = wval_q;
    rval0_d = rval0_q;
    rval1_d = rval1_q;
    fault_d = fault_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    wtrig_d = 1'b0;
    rtrig_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_err) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (ram_controller_ready && pick_valid) begin
          owner_d = pick_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          mask_d  = sel_mask;
          wval_d  = sel_wval;
          wtrig_d = sel_we;
          rtrig_d = ~sel_we;
          state_d = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        // The controller still reports ready while the trigger is on the wire.
        if (ram_err) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (!wtrig_q && !rtrig_q && !ram_controller_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ram_err) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (we_q ? ram_controller_ready : ram_read_value_ready) begin
          if (owner_q == PORT_DATA) begin
            done1_d = 1'b1;
            if (!we_q) rval1_d = ram_read_value;
          end else begin
            done0_d = 1'b1;
            if (!we_q) rval0_d = ram_read_value;
          end
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      FAULT:   fault_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      owner_q <= PORT_FETCH;
      addr_q  <= '0;
      mask_q  <= '0;
      wval_q  <= '0;
      rval0_q <= '0;
      rval1_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      wtrig_q <= 1'b0;
      rtrig_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wval_q  <= wval_d;
      rval0_q <= rval0_d;
      rval1_q <= rval1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      wtrig_q <= wtrig_d;
      rtrig_q <= rtrig_d;
      fault_q <= fault_d;
    end
  end

  assign p0_done           = done0_q;
  assign p1_done           = done1_q;
  assign p0_read_value     = rval0_q;
  assign p1_read_value     = rval1_q;
  assign ram_address       = addr_q;
  assign ram_mask          = mask_q;
  assign ram_write_value   = wval_q;
  assign ram_write_trigger = wtrig_q;
  assign ram_read_trigger  = rtrig_q;
  assign fault             = fault_q;
  assign grant_owner       = owner_q;

endmodule
